memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/memory_arbiter.sv | 152 +++++++++++++++
 tb/tb_memory_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared constants and FSM encoding for the two-port memory arbiter.
package memory_pkg;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int DATA_W = 8;

   // One command slot, an optional read-response slot, then back to idle.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. A lone requester always wins; on a tie the
// pointer names the winner. Every accepted pick moves the pointer to the
// other port, so a held tie alternates 0,1,0,1 starting from port 0.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       take_i,
   output logic       winner_o
);

   logic ptr_q, ptr_d;

   // Winner selection and pointer update for the current pick.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
      winner_o = req_i[1];
      ptr_d    = ptr_q;
      if (req_i == 2'b11) begin
         winner_o = ptr_q;
      end
      if (take_i && (req_i != 2'b00)) begin
         ptr_d = ~winner_o;
      end
   end

   // Priority pointer register; port 0 has priority out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single-port-per-direction synchronous
// memory. IDLE captures the winning command, ACCESS issues it and pulses the
// winner's gnt, RESP returns read data with the winner's rvalid.
// Optional grant counters are built when MEMORY_ARBITER_STATS_EN is defined.
module memory_arbiter
   import memory_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_w_en,
   output logic              mem_r_en,
   output logic [ADDR_W-1:0] mem_w_addr,
   output logic [ADDR_W-1:0] mem_r_addr,
   output logic [DATA_W-1:0] mem_w_data,
   input  logic [DATA_W-1:0] mem_r_data
`ifdef MEMORY_ARBITER_STATS_EN
   ,
   output logic [7:0]        gnt_cnt0,
   output logic [7:0]        gnt_cnt1
`endif
);

   state_t              state_q, state_d;
   logic                port_q, port_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                take;
   logic                winner;
   logic [NUM_PORTS-1:0] req_vec, gnt_vec, rvalid_vec;

   assign req_vec = {req1, req0};

   rr_arbiter2 u_rr (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req_vec),
      .take_i   (take),
      .winner_o (winner)
   );

   // Next-state logic: capture the winner's command once, then walk the FSM.
   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      take    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_vec != '0) begin
               take    = 1'b1;
               port_d  = winner;
               we_d    = winner ? we1    : we0;
               addr_d  = winner ? addr1  : addr0;
               wdata_d = winner ? wdata1 : wdata0;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: state_d = we_q ? ST_IDLE : ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State and captured-command registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Output decode: memory bus and gnt only in ACCESS, read data only in RESP.
   always_comb begin
      mem_w_en   = 1'b0;
      mem_r_en   = 1'b0;
      mem_w_addr = '0;
      mem_r_addr = '0;
      mem_w_data = '0;
      rdata      = '0;
      gnt_vec    = '0;
      rvalid_vec = '0;
      case (state_q)
         ST_ACCESS: begin
            gnt_vec[port_q] = 1'b1;
            if (we_q) begin
               mem_w_en   = 1'b1;
               mem_w_addr = addr_q;
               mem_w_data = wdata_q;
            end else begin
               mem_r_en   = 1'b1;
               mem_r_addr = addr_q;
            end
         end
         ST_RESP: begin
            rvalid_vec[port_q] = 1'b1;
            rdata              = mem_r_data;
         end
         default: ;
      endcase
   end

   assign gnt0    = gnt_vec[0];
   assign gnt1    = gnt_vec[1];
   assign rvalid0 = rvalid_vec[0];
   assign rvalid1 = rvalid_vec[1];

`ifdef MEMORY_ARBITER_STATS_EN
   logic [7:0] cnt0_q, cnt1_q;

   // Per-port grant counters, saturating at 255.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= 8'd0;
         cnt1_q <= 8'd0;
      end else begin
         if (gnt_vec[0] && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
         if (gnt_vec[1] && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed stimulus pushes the expected
// gnt/rvalid events (with their cycle) into a queue, and a negedge monitor
// pops and compares whenever the DUT pulses gnt or rvalid.
module tb_memory_arbiter;

   localparam int K_GNT = 0;
   localparam int K_RV  = 1;

   typedef struct {
      int         kind;
      int         port;
      logic [7:0] data;
      int         at;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [3:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] rdata;
   logic       mem_w_en, mem_r_en;
   logic [3:0] mem_w_addr, mem_r_addr;
   logic [7:0] mem_w_data, mem_r_data;
`ifdef MEMORY_ARBITER_STATS_EN
   logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] mem [16];

   memory_arbiter #(.NUM_PORTS(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .req1       (req1),
      .we0        (we0),
      .we1        (we1),
      .addr0      (addr0),
      .addr1      (addr1),
      .wdata0     (wdata0),
      .wdata1     (wdata1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .rvalid0    (rvalid0),
      .rvalid1    (rvalid1),
      .rdata      (rdata),
      .mem_w_en   (mem_w_en),
      .mem_r_en   (mem_r_en),
      .mem_w_addr (mem_w_addr),
      .mem_r_addr (mem_r_addr),
      .mem_w_data (mem_w_data),
      .mem_r_data (mem_r_data)
`ifdef MEMORY_ARBITER_STATS_EN
      ,
      .gnt_cnt0   (gnt_cnt0),
      .gnt_cnt1   (gnt_cnt1)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural memory: word i holds i at start, one-cycle synchronous read.
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(i);
      mem_r_data = 8'h00;
   end

   always @(posedge clk) begin
      if (mem_w_en) mem[mem_w_addr] = mem_w_data;
      if (mem_r_en) mem_r_data <= mem[mem_r_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int port, input logic [7:0] data, input int at);
      exp_t e;
      e.kind = kind;
      e.port = port;
      e.data = data;
      e.at   = at;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input int kind, input int port);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_unexpected: got kind %0d port %0d, expected no event (cycle %0d)", kind, port, cyc);
      end else begin
         e = sb_q.pop_front();
         check("sb_kind", 32'(kind), 32'(e.kind));
         check("sb_port", 32'(port), 32'(e.port));
         check("sb_cycle", 32'(cyc), 32'(e.at));
         if (e.kind == K_RV) check("sb_rdata", 32'(rdata), 32'(e.data));
      end
   endtask

   // Monitor: structural invariants every cycle, scoreboard on each pulse.
   always @(negedge clk) begin
      check("wr_en_overlap", 32'(mem_w_en & mem_r_en), 32'd0);
      check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
      check("rvalid_excl", 32'(rvalid0 & rvalid1), 32'd0);
      if (!(rvalid0 | rvalid1)) check("rdata_idle", 32'(rdata), 32'd0);
      if (gnt0)    sb_pop(K_GNT, 0);
      if (gnt1)    sb_pop(K_GNT, 1);
      if (rvalid0) sb_pop(K_RV, 0);
      if (rvalid1) sb_pop(K_RV, 1);
   end

   task automatic check_quiet(input string tag);
      check({tag, "_strobes"}, 32'({gnt0, gnt1, rvalid0, rvalid1, mem_w_en, mem_r_en}), 32'd0);
      check({tag, "_w_addr"}, 32'(mem_w_addr), 32'd0);
      check({tag, "_r_addr"}, 32'(mem_r_addr), 32'd0);
      check({tag, "_w_data"}, 32'(mem_w_data), 32'd0);
      check({tag, "_rdata"}, 32'(rdata), 32'd0);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
      if (p == 0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   // Requester: holds its command until it has seen n grants, then drops.
   task automatic hold(input int p, input logic w, input logic [3:0] a, input logic [7:0] d, input int n);
      int got    = 0;
      int budget = 6 * n + 20;
      drive(p, 1'b1, w, a, d);
      while (got < n && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
         if ((p == 0 && gnt0) || (p == 1 && gnt1)) got++;
      end
      if (got < n) begin
         n_checks++;
         n_fail++;
         $display("FAIL hold_timeout: port %0d got %0d grants, expected %0d", p, got, n);
      end else begin
         @(posedge clk);
         #1;
      end
      drive(p, 1'b0, 1'b0, 4'h0, 8'h00);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
      drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(2);

      // Port 0 reads word 3: gnt at +1, rvalid at +2.
      n = cyc;
      push(K_GNT, 0, 8'h00, n + 1);
      push(K_RV, 0, 8'h03, n + 2);
      hold(0, 1'b0, 4'h3, 8'h00, 1);
      tick(2);

      // Port 1 writes 0xA5 to the top address, then reads it back.
      n = cyc;
      push(K_GNT, 1, 8'h00, n + 1);
      hold(1, 1'b1, 4'hF, 8'hA5, 1);
      tick(1);
      n = cyc;
      push(K_GNT, 1, 8'h00, n + 1);
      push(K_RV, 1, 8'hA5, n + 2);
      hold(1, 1'b0, 4'hF, 8'h00, 1);
      tick(2);

      // Bottom address through port 0: write 0x3C to 0, read back.
      n = cyc;
      push(K_GNT, 0, 8'h00, n + 1);
      hold(0, 1'b1, 4'h0, 8'h3C, 1);
      tick(1);
      n = cyc;
      push(K_GNT, 0, 8'h00, n + 1);
      push(K_RV, 0, 8'h3C, n + 2);
      hold(0, 1'b0, 4'h0, 8'h00, 1);
      tick(2);

      // Simultaneous reads right after reset: port 0 first, then port 1.
      pulse_reset();
      n = cyc;
      push(K_GNT, 0, 8'h00, n + 1);
      push(K_RV, 0, 8'h01, n + 2);
      push(K_GNT, 1, 8'h00, n + 4);
      push(K_RV, 1, 8'h02, n + 5);
      fork
         hold(0, 1'b0, 4'h1, 8'h00, 1);
         hold(1, 1'b0, 4'h2, 8'h00, 1);
      join
      tick(2);

      // Both held for six reads: grants alternate 0,1,0,1,0,1.
      n = cyc;
      for (int k = 0; k < 6; k++) begin
         push(K_GNT, k % 2, 8'h00, n + 1 + 3 * k);
         push(K_RV, k % 2, (k % 2 == 0) ? 8'h05 : 8'h06, n + 2 + 3 * k);
      end
      fork
         hold(0, 1'b0, 4'h5, 8'h00, 3);
         hold(1, 1'b0, 4'h6, 8'h00, 3);
      join
      tick(2);

      // Reset lands in the ACCESS cycle of a write: no gnt, outputs cleared.
      drive(0, 1'b1, 1'b1, 4'h4, 8'h5A);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      check_quiet("abort");
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
      rst_n = 1'b1;
      tick(2);
      // Back in IDLE: a fresh read sees uncontended latency and the old word.
      n = cyc;
      push(K_GNT, 0, 8'h00, n + 1);
      push(K_RV, 0, 8'h04, n + 2);
      hold(0, 1'b0, 4'h4, 8'h00, 1);
      tick(2);

`ifdef MEMORY_ARBITER_STATS_EN
      // 300 port-0 writes saturate its counter; port 1 stays at zero.
      pulse_reset();
      check("cnt0_reset", 32'(gnt_cnt0), 32'd0);
      check("cnt1_reset", 32'(gnt_cnt1), 32'd0);
      n = cyc;
      for (int k = 0; k < 300; k++) push(K_GNT, 0, 8'h00, n + 1 + 2 * k);
      hold(0, 1'b1, 4'h7, 8'h11, 300);
      tick(2);
      check("cnt0_sat", 32'(gnt_cnt0), 32'd255);
      check("cnt1_zero", 32'(gnt_cnt1), 32'd0);
`endif

      tick(3);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
